// File: rtl/dipsw_scan_ctrl_if.sv
// dipsw_scan_ctrl_if: Avalon-MM slave bus plus interrupt line for the DIP switch scanner
interface dipsw_scan_ctrl_if;
  logic [1:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  modport master(output address, read, write, writedata, input readdata, irq);
  modport slave(input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/dipsw_scan_ctrl.sv
// dipsw_scan_ctrl: debounced DIP switch/button PIO with sticky edge capture and irq (option macro DIPSW_SCAN_BOTHEDGE_EN)
module dipsw_scan_ctrl #(
  parameter int WIDTH = 10,
  parameter int SAMPLE_DIV = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic clk,
  input logic reset,
  dipsw_scan_ctrl_if.slave bus,
  input logic [WIDTH-1:0] in_port
);
  localparam int DW = $clog2(SAMPLE_DIV);
  logic [WIDTH-1:0] sync1, sync_in, last_sample, debounced, edgecap, mask;
  logic [WIDTH-1:0] nxt_sample, nxt_deb, edge_set, clr;
  logic [DW-1:0] div_cnt;
  logic [3:0] stable_cnt, nxt_cnt;
  logic tick, wr_mask, unused;
  assign unused = &{1'b0, bus.read, bus.writedata};
  // next-state of prescaler tick, debounce counter and edge detection
  always_comb begin
    tick = div_cnt == DW'(SAMPLE_DIV - 1);
    nxt_sample = tick ? sync_in : last_sample;
    nxt_cnt = !tick ? stable_cnt :
              sync_in != last_sample ? 4'd1 :
              stable_cnt < 4'(DEBOUNCE_CNT) ? stable_cnt + 4'd1 : stable_cnt;
    nxt_deb = tick && nxt_cnt == 4'(DEBOUNCE_CNT) ? nxt_sample : debounced;
`ifdef DIPSW_SCAN_BOTHEDGE_EN
    edge_set = nxt_deb ^ debounced;
`else
    edge_set = nxt_deb & ~debounced;
`endif
    wr_mask = bus.write && bus.address == 2'd2;
    clr = bus.write && bus.address == 2'd3 ? bus.writedata[WIDTH-1:0] : '0;
  end
  // synchroniser, prescaler and whole-vector debounce state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync_in <= '0;
      div_cnt <= '0;
      last_sample <= '0;
      stable_cnt <= '0;
      debounced <= '0;
    end else begin
      sync1 <= in_port;
      sync_in <= sync1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      last_sample <= nxt_sample;
      stable_cnt <= nxt_cnt;
      debounced <= nxt_deb;
    end
  end
  // register file: sticky edge capture (set beats clear), mask, irq and registered read mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecap <= '0;
      mask <= '0;
      bus.irq <= 1'b0;
      bus.readdata <= '0;
    end else begin
      edgecap <= (edgecap & ~clr) | edge_set;
      mask <= wr_mask ? bus.writedata[WIDTH-1:0] : mask;
      bus.irq <= |(edgecap & mask);
      bus.readdata <= bus.address == 2'd0 ? 32'(debounced) :
                      bus.address == 2'd1 ? 32'(sync_in) :
                      bus.address == 2'd2 ? 32'(mask) : 32'(edgecap);
    end
  end
endmodule

// File: tb/tb_dipsw_scan_ctrl.sv
// tb_dipsw_scan_ctrl: directed vector table plus hand sequences for debounce, edge capture and irq
module tb_dipsw_scan_ctrl;
  logic clk = 0;
  logic reset;
  logic [9:0] in_port;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [9:0] in;
    logic [9:0] deb;
  } vec_t;
  vec_t tbl[21];
  dipsw_scan_ctrl_if bus();
  dipsw_scan_ctrl #(.WIDTH(10), .SAMPLE_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .in_port(in_port)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic align(input int r);
    while (cyc % 4 != r) step(1);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1;
    step(1);
    bus.write = 0;
  endtask
  initial begin
    tbl = '{'{10'h005, 10'h000}, '{10'h005, 10'h000}, '{10'h005, 10'h000},
            '{10'h004, 10'h005}, '{10'h004, 10'h005}, '{10'h004, 10'h005},
            '{10'h005, 10'h004}, '{10'h004, 10'h004}, '{10'h005, 10'h004},
            '{10'h004, 10'h004}, '{10'h005, 10'h004}, '{10'h004, 10'h004},
            '{10'h005, 10'h004}, '{10'h004, 10'h004}, '{10'h005, 10'h004},
            '{10'h004, 10'h004}, '{10'h005, 10'h004}, '{10'h005, 10'h004},
            '{10'h005, 10'h004}, '{10'h005, 10'h005}, '{10'h005, 10'h005}};
    reset = 1;
    in_port = 0;
    bus.address = 0;
    bus.read = 0;
    bus.write = 0;
    bus.writedata = 0;
    step(2);
    check("rst_readdata", bus.readdata, 0);
    check("rst_irq", {31'd0, bus.irq}, 0);
    reset = 0;
    step(1);
    for (int i = 0; i < 21; i++) begin
      check($sformatf("deb_vec%0d", i), bus.readdata, {22'd0, tbl[i].deb});
      check($sformatf("irq_vec%0d", i), {31'd0, bus.irq}, 0);
      in_port = tbl[i].in;
      step(4);
    end
    in_port = 0;
    bus.address = 1;
    step(3);
    in_port = 10'h005;
    step(2);
    check("sync_early", bus.readdata, 0);
    step(1);
    check("sync_lat", bus.readdata, 32'h005);
    wr(2, 32'hFFFF_FFFF);
    step(1);
    check("mask_width", bus.readdata, 32'h3FF);
    wr(2, 32'h001);
    in_port = 10'h004;
    step(20);
    wr(3, 32'h3FF);
    bus.address = 3;
    step(1);
    check("ecap_cleared", bus.readdata, 0);
    check("irq_cleared", {31'd0, bus.irq}, 0);
    align(1);
    in_port = 10'h005;
    step(11);
    check("ecap_early", bus.readdata, 0);
    check("irq_early", {31'd0, bus.irq}, 0);
    step(1);
    check("ecap_rise", bus.readdata, 32'h001);
    check("irq_rise", {31'd0, bus.irq}, 1);
    bus.writedata = 32'h001;
    bus.write = 1;
    step(1);
    bus.write = 0;
    check("irq_hold", {31'd0, bus.irq}, 1);
    step(1);
    check("irq_clear", {31'd0, bus.irq}, 0);
    check("ecap_clear", bus.readdata, 0);
    align(1);
    in_port = 10'h007;
    step(10);
    bus.writedata = 32'h002;
    bus.write = 1;
    step(1);
    bus.write = 0;
    step(1);
    check("set_wins", bus.readdata, 32'h002);
    check("irq_unmasked", {31'd0, bus.irq}, 0);
    in_port = 10'h001;
    step(20);
    wr(3, 32'h3FF);
    in_port = 10'h000;
    step(20);
`ifdef DIPSW_SCAN_BOTHEDGE_EN
    check("ecap_fall", bus.readdata, 32'h001);
    check("irq_fall", {31'd0, bus.irq}, 1);
`else
    check("ecap_fall", bus.readdata, 0);
    check("irq_fall", {31'd0, bus.irq}, 0);
`endif
    in_port = 10'h3FF;
    step(20);
    check("irq_pre_rst", {31'd0, bus.irq}, 1);
    bus.address = 0;
    step(1);
    check("deb_pre_rst", bus.readdata, 32'h3FF);
    reset = 1;
    #1;
    check("midrst_readdata", bus.readdata, 0);
    check("midrst_irq", {31'd0, bus.irq}, 0);
    step(2);
    reset = 0;
    step(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_redeb%0d", k), bus.readdata, k < 3 ? 32'h0 : 32'h3FF);
      step(4);
    end
    bus.address = 2;
    step(1);
    check("mask_rst", bus.readdata, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dipsw_scan_ctrl.md
Name: dipsw_scan_ctrl

Overview:
- Avalon-MM slave controller for the board DIP switch / push-button input port.
- Synchronises the raw pins and sequences periodic sampling with a prescaler.
- Debounces the samples and captures edges into a sticky register.
- Raises an interrupt to the Nios II through the system interconnect, where the plain input PIO is insufficient for mechanical switches.

Parameters:
- WIDTH, 10, number of input pins (1..32).
- SAMPLE_DIV, 50000, clk cycles between sample ticks (>=2); 1 ms at 50 MHz.
- DEBOUNCE_CNT, 4, consecutive identical samples required before a value is accepted (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- irq  out  1  level interrupt request.
- in_port  in  WIDTH  raw asynchronous switch pins.

Behaviour:
- Reset (asynchronous, active-high):
  - sync FFs, sample register, debounced register, edge-capture, irq mask, counters: 0.
  - readdata = 0; irq = 0.
- Synchroniser: 2-FF chain on in_port gives sync_in. Input-to-sync_in latency is 2 clk.
- Prescaler:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is a 1-cycle pulse when div_cnt == SAMPLE_DIV-1.
- Debounce (whole vector, on tick only):
  - If sync_in != last_sample: last_sample <= sync_in, stable_cnt <= 1.
  - Else if stable_cnt < DEBOUNCE_CNT: stable_cnt <= stable_cnt + 1.
  - When stable_cnt reaches DEBOUNCE_CNT, debounced <= last_sample on that same tick. It stays saturated (no re-count) until the next mismatch.
  - With DEBOUNCE_CNT=1, every sample is accepted immediately.
  - Glitches shorter than one tick period that are not present at the tick are invisible.
- Edge capture:
  - On the cycle debounced changes, edgecap[i] sets for each bit with a 0->1 transition.
  - Sticky until cleared.
  - Write address 3: bits with writedata[i]=1 clear. A set in the same cycle as a clear wins (bit remains 1).
- irq = |(edgecap & mask). Registered, 1 clk after edgecap/mask update. Deasserts 1 clk after clear.
- Register map (bits above WIDTH read 0, writes ignored):
  - 0 R: debounced value.
  - 1 R: sync_in (raw, synchronised).
  - 2 RW: irq mask.
  - 3 R/W1C: edge capture.
- Read: readdata registered from address on every clk (read latency 1, same as the team's PIO). The read strobe is a don't-care. Writes to addresses 0/1 are ignored.
- Reset mid-debounce: all state is discarded. After release, debounce restarts from last_sample=0, stable_cnt=0.

Optional Feature:
- Macro DIPSW_SCAN_BOTHEDGE_EN.
- Defined: edgecap[i] sets on any change of debounced[i] (0->1 or 1->0).
- Undefined: rising edges only; falling edges are ignored for capture and irq.
- The register map is unchanged either way.

Test Plan:
- Bench uses SAMPLE_DIV=4, DEBOUNCE_CNT=3, WIDTH=10.
- Reset asserted mid-run with in_port=10'h3FF -> readdata=0, irq=0 during reset. After release, address0 reads 0 until 3 identical ticks have passed, then reads 0x3FF.
- in_port 0 -> 0x005 held steady -> address1 reads 0x005 after 2 clk plus read latency. Address0 becomes 0x005 on the 3rd tick after the sample change (~12 clk), not before.
- in_port toggles bit0 every tick (bounce) for 10 ticks, then holds 1 -> address0 bit0 stays 0 throughout the bounce and becomes 1 three ticks after holding.
- Mask=0x001, debounced bit0 rises -> edgecap=0x001, irq=1 one clk later. Write 0x001 to address 3 -> irq=0 one clk later, edgecap=0.
- A clear write lands on the same cycle as a new rising-edge set on bit1 -> edgecap bit1 remains 1.
- Falling edge 0x001 -> 0x000 -> edgecap stays 0 without DIPSW_SCAN_BOTHEDGE_EN; edgecap=0x001 and irq=1 with it defined.
